// File: rtl/d_sram_to_sram_like_p_if.sv
// SRAM-like bus between the data-side bridge and the AXI-lite conversion layer.
// master: the bridge issuing requests; slave: the bus side answering them.
interface d_sram_to_sram_like_p_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/d_sram_to_sram_like_p.sv
// Data-side bridge: CPU SRAM-style port -> SRAM-like bus, one transaction at a time.
// Request fields are combinational; the pipeline keeps its inputs stable while stalled.
//
// state  | meaning
// IDLE   | no transaction outstanding; request driven straight from data_sram_en
// WAIT   | address accepted, waiting for data_data_ok
// DONE   | response captured; stall released (held while longest_stall if HOLD_UNTIL_RELEASE)
module d_sram_to_sram_like_p #(
    parameter int ADDR_W             = 32,
    parameter bit HOLD_UNTIL_RELEASE = 1'b1,
    parameter int TIMEOUT_CYCLES     = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_data_sram_en,
    input  logic [3:0]        i_data_sram_wen,
    input  logic [ADDR_W-1:0] i_data_sram_addr,
    input  logic [31:0]       i_data_sram_wdata,
    output logic [31:0]       o_data_sram_rdata,
    output logic              o_d_stall,
    input  logic              i_longest_stall,
    output logic              o_wen_illegal,
    output logic              o_timeout_err,
    d_sram_to_sram_like_p_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_req;
    logic        w_capture;
    logic        w_wr;
    logic [1:0]  w_size;
    logic [1:0]  w_addr_lo;
    logic        w_pattern_bad;
    logic [31:0] r_rdata;

    assign w_wr = |i_data_sram_wen;

    // Size and low address bits derived from the byte-enable pattern
    always_comb begin
        w_size        = 2'b10;
        w_addr_lo     = i_data_sram_addr[1:0];
        w_pattern_bad = 1'b0;
        case (i_data_sram_wen)
            4'b0000: ;
            4'b1111: w_addr_lo = 2'b00;
            4'b0011: begin w_size = 2'b01; w_addr_lo = 2'b00; end
            4'b1100: begin w_size = 2'b01; w_addr_lo = 2'b10; end
            4'b0001: begin w_size = 2'b00; w_addr_lo = 2'b00; end
            4'b0010: begin w_size = 2'b00; w_addr_lo = 2'b01; end
            4'b0100: begin w_size = 2'b00; w_addr_lo = 2'b10; end
            4'b1000: begin w_size = 2'b00; w_addr_lo = 2'b11; end
            default: begin w_addr_lo = 2'b00; w_pattern_bad = 1'b1; end
        endcase
    end

    assign bus.data_req   = w_req;
    assign bus.data_wr    = w_wr;
    assign bus.data_size  = w_size;
    assign bus.data_addr  = {i_data_sram_addr[ADDR_W-1:2], w_addr_lo};
    assign bus.data_wdata = i_data_sram_wdata;
    assign o_wen_illegal  = i_data_sram_en & w_pattern_bad;
    assign o_d_stall      = i_data_sram_en & (r_state != S_DONE);
    assign o_data_sram_rdata = r_rdata;

    // State register and read-data capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_capture && !w_wr)
                r_rdata <= bus.data_rdata;
        end
    end

    // Next-state, request and capture decode
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req = i_data_sram_en;
                if (i_data_sram_en && bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        w_next    = S_DONE;
                        w_capture = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.data_data_ok) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end
            end
            S_DONE: begin
                if (!HOLD_UNTIL_RELEASE || !i_longest_stall)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] r_wd_cnt;
            logic          r_timeout;
            logic          w_cnt_en;
            logic          w_enter_done;

            assign w_cnt_en     = ((r_state == S_IDLE) && w_req && !bus.data_addr_ok)
                                || (r_state == S_WAIT);
            assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
            assign o_timeout_err = r_timeout;

            // Saturating outstanding-cycle counter with sticky timeout flag
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_wd_cnt  <= '0;
                    r_timeout <= 1'b0;
                end else begin
                    if (w_enter_done)
                        r_wd_cnt <= '0;
                    else if (w_cnt_en && (r_wd_cnt != LIMIT))
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (r_wd_cnt == LIMIT)
                        r_timeout <= 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign o_timeout_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_d_sram_to_sram_like_p.sv
// Directed bench for the data-side SRAM bridge. Stimulus pushes the expected
// read-data value at every completing transaction; a monitor pops and checks
// it when the DUT releases the stall for an active request.
module tb_d_sram_to_sram_like_p;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sram_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        wen_illegal;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_rdata;
    logic        prev_stall;

    d_sram_to_sram_like_p_if #(.ADDR_W(32)) bus ();

    d_sram_to_sram_like_p #(
        .ADDR_W(32),
        .HOLD_UNTIL_RELEASE(1'b1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .i_data_sram_en    (en),
        .i_data_sram_wen   (wen),
        .i_data_sram_addr  (addr),
        .i_data_sram_wdata (wdata),
        .o_data_sram_rdata (sram_rdata),
        .o_d_stall         (d_stall),
        .i_longest_stall   (longest_stall),
        .o_wen_illegal     (wen_illegal),
        .o_timeout_err     (timeout_err),
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: a stall release on an active request marks a completed transaction
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && en && !d_stall && prev_stall) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_completion: got rdata %h want none", sram_rdata);
                end else begin
                    chk("complete_rdata", sram_rdata, exp_q.pop_front());
                end
            end
            prev_stall = d_stall;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    // One-cycle write with addr_ok and data_ok together, then release
    task automatic do_wr(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] exp_size, input logic [31:0] exp_addr,
                         input logic exp_ill);
        step();
        en = 1'b1; wen = w; addr = a; wdata = d;
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5A5A5;
        exp_q.push_back(exp_rdata);
        mid();
        chk("wr_req",  {31'd0, bus.data_req}, 32'd1);
        chk("wr_wr",   {31'd0, bus.data_wr}, 32'd1);
        chk("wr_size", {30'd0, bus.data_size}, {30'd0, exp_size});
        chk("wr_addr", bus.data_addr, exp_addr);
        chk("wr_wdata", bus.data_wdata, d);
        chk("wr_illegal", {31'd0, wen_illegal}, {31'd0, exp_ill});
        chk("wr_stall", {31'd0, d_stall}, 32'd1);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        mid();
        chk("wr_done_req", {31'd0, bus.data_req}, 32'd0);
        chk("wr_done_stall", {31'd0, d_stall}, 32'd0);
        step();
        en = 1'b0;
        mid();
    endtask

    typedef struct {
        logic [3:0]  w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] ea;
        logic        ill;
    } wvec_t;

    wvec_t wv[7];

    initial begin
        wv[0] = '{4'b0100, 32'h0000_1003, 2'b00, 32'h0000_1002, 1'b0};
        wv[1] = '{4'b0110, 32'h0000_4001, 2'b10, 32'h0000_4000, 1'b1};
        wv[2] = '{4'b1100, 32'h0000_5001, 2'b01, 32'h0000_5002, 1'b0};
        wv[3] = '{4'b1111, 32'h0000_5003, 2'b10, 32'h0000_5000, 1'b0};
        wv[4] = '{4'b0011, 32'h0000_5002, 2'b01, 32'h0000_5000, 1'b0};
        wv[5] = '{4'b1000, 32'h0000_5000, 2'b00, 32'h0000_5003, 1'b0};
        wv[6] = '{4'b1001, 32'h0000_6002, 2'b10, 32'h0000_6000, 1'b1};

        resetn = 1'b0; en = 1'b0; wen = 4'd0; addr = 32'd0; wdata = 32'd0;
        longest_stall = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        exp_rdata = 32'd0;
        step(); step();
        resetn = 1'b1;
        mid();
        chk("rst_rdata", sram_rdata, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        chk("rst_stall", {31'd0, d_stall}, 32'd0);
        chk("rst_req", {31'd0, bus.data_req}, 32'd0);

        // Read: addr_ok at cycle 0, data_ok at cycle 3
        step();
        en = 1'b1; wen = 4'b0000; addr = 32'h0000_2001; bus.data_addr_ok = 1'b1;
        exp_rdata = 32'hDEADBEEF;
        exp_q.push_back(exp_rdata);
        mid();
        chk("rd_req_c0", {31'd0, bus.data_req}, 32'd1);
        chk("rd_stall_c0", {31'd0, d_stall}, 32'd1);
        chk("rd_wr", {31'd0, bus.data_wr}, 32'd0);
        chk("rd_size", {30'd0, bus.data_size}, 32'd2);
        chk("rd_addr", bus.data_addr, 32'h0000_2001);
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.data_addr_ok = 1'b0;
            if (c == 3) begin
                bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF;
            end
            mid();
            chk("rd_req_wait", {31'd0, bus.data_req}, 32'd0);
            chk("rd_stall_wait", {31'd0, d_stall}, 32'd1);
        end
        step();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        mid();
        chk("rd_stall_c4", {31'd0, d_stall}, 32'd0);
        chk("rd_rdata_c4", sram_rdata, 32'hDEADBEEF);
        step();
        en = 1'b0;
        mid();

        // Writes across the byte-enable patterns, legal and illegal
        for (int i = 0; i < 7; i++)
            do_wr(wv[i].w, wv[i].a, 32'h1122_3344 + i, wv[i].sz, wv[i].ea, wv[i].ill);
        wen = 4'b0110;
        mid();
        chk("illegal_en_low", {31'd0, wen_illegal}, 32'd0);
        chk("rdata_after_writes", sram_rdata, 32'hDEADBEEF);
        wen = 4'b0000;

        // Hold in DONE while longest_stall stays high
        step();
        en = 1'b1; addr = 32'h0000_3000; longest_stall = 1'b1;
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
        exp_rdata = 32'h1234_5678;
        exp_q.push_back(exp_rdata);
        mid();
        chk("hold_req_c0", {31'd0, bus.data_req}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
            mid();
            chk("hold_req", {31'd0, bus.data_req}, 32'd0);
            chk("hold_stall", {31'd0, d_stall}, 32'd0);
        end
        step();
        longest_stall = 1'b0;
        mid();
        chk("hold_release_req", {31'd0, bus.data_req}, 32'd0);
        step();
        addr = 32'h0000_3004;
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
        exp_rdata = 32'hCAFE_F00D;
        exp_q.push_back(exp_rdata);
        mid();
        chk("hold_next_req", {31'd0, bus.data_req}, 32'd1);
        chk("hold_next_stall", {31'd0, d_stall}, 32'd1);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        mid();
        step();
        en = 1'b0;
        mid();

        // Watchdog: addr_ok withheld for 6 cycles
        step();
        en = 1'b1; addr = 32'h0000_6000;
        mid();
        chk("wd_req", {31'd0, bus.data_req}, 32'd1);
        chk("wd_err_c0", {31'd0, timeout_err}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            mid();
            if (c == 2) chk("wd_err_early", {31'd0, timeout_err}, 32'd0);
            if (c == 5) chk("wd_err_set", {31'd0, timeout_err}, 32'd1);
        end
        step();
        bus.data_addr_ok = 1'b1;
        mid();
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_F00D;
        exp_rdata = 32'h0BAD_F00D;
        exp_q.push_back(exp_rdata);
        mid();
        step();
        bus.data_data_ok = 1'b0;
        mid();
        chk("wd_err_after_done", {31'd0, timeout_err}, 32'd1);
        step();
        en = 1'b0;
        mid();
        chk("wd_err_sticky", {31'd0, timeout_err}, 32'd1);
        step();
        resetn = 1'b0;
        mid();
        step();
        resetn = 1'b1;
        mid();
        exp_rdata = 32'd0;
        chk("wd_err_cleared", {31'd0, timeout_err}, 32'd0);
        chk("wd_rst_rdata", sram_rdata, 32'd0);

        // Reset while in WAIT, then a stray data_ok
        step();
        en = 1'b1; addr = 32'h0000_7000; bus.data_addr_ok = 1'b1;
        mid();
        step();
        bus.data_addr_ok = 1'b0;
        mid();
        chk("rw_stall_wait", {31'd0, d_stall}, 32'd1);
        step();
        resetn = 1'b0; en = 1'b0;
        mid();
        step();
        resetn = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
        mid();
        chk("rw_rdata_rst", sram_rdata, 32'd0);
        chk("rw_req_idle", {31'd0, bus.data_req}, 32'd0);
        step();
        bus.data_data_ok = 1'b0;
        mid();
        chk("rw_stray_ignored", sram_rdata, 32'd0);
        step();
        en = 1'b1; addr = 32'h0000_7004;
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55AA_55AA;
        exp_rdata = 32'h55AA_55AA;
        exp_q.push_back(exp_rdata);
        mid();
        chk("rw_next_req", {31'd0, bus.data_req}, 32'd1);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        mid();
        step();
        en = 1'b0;
        mid();

        step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_sram_to_sram_like_p.md
Name: d_sram_to_sram_like_p

Overview:
- Parametrised data-side bridge from the CPU's SRAM-style memory port to the SRAM-like bus, one transaction at a time.
- Successor to the instruction-only bridge; adds writes with byte enables and size/address derivation from the byte enables.
- Adds a selectable hold mode for multi-stage stalls and an optional watchdog counter.
- Sits between the MEM stage and the AXI-lite conversion layer.

Parameters:
- ADDR_W, 32, address width passed through unchanged.
- HOLD_UNTIL_RELEASE, 1. 1: the result is held in DONE until longest_stall drops. 0: DONE lasts exactly one cycle.
- TIMEOUT_CYCLES, 0. Watchdog limit, in cycles, while a transaction is outstanding. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- data_sram_en  in  1  access request from the pipeline
- data_sram_wen  in  4  byte write enables; 0000 means read
- data_sram_addr  in  ADDR_W  byte address
- data_sram_wdata  in  32  write data, in lane position
- data_sram_rdata  out  32  captured read data
- d_stall  out  1  stall request to the pipeline
- data_req  out  1  SRAM-like request
- data_wr  out  1  1 = write
- data_size  out  2  00 = byte, 01 = half, 10 = word
- data_addr  out  ADDR_W  request address
- data_wdata  out  32  write data
- data_addr_ok  in  1  address handshake
- data_data_ok  in  1  data/response handshake
- data_rdata  in  32  read data
- longest_stall  in  1  any pipeline stall still active
- wen_illegal  out  1  combinational flag: current wen pattern is unsupported
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Single clock. Synchronous, active-low reset.
- Reset (resetn=0 at a clk edge): state=IDLE, data_sram_rdata=0, timeout_err=0, watchdog count=0.
- Reset mid-transaction abandons the transaction. Any later data_data_ok is ignored until the next request.
- States are IDLE, WAIT and DONE.
- IDLE:
  - data_req = data_sram_en (combinational, zero-latency request).
  - data_sram_en & data_addr_ok & data_data_ok in the same cycle: go to DONE and capture the data.
  - data_sram_en & data_addr_ok alone: go to WAIT.
  - Otherwise: stay in IDLE.
  - data_data_ok while in IDLE without data_addr_ok is ignored.
- WAIT:
  - data_req = 0.
  - data_data_ok: capture the data and go to DONE.
  - data_addr_ok is ignored.
- DONE:
  - data_req = 0.
  - HOLD_UNTIL_RELEASE=1: go to IDLE on the first cycle with longest_stall=0.
  - HOLD_UNTIL_RELEASE=0: go to IDLE unconditionally after one cycle.
- d_stall = data_sram_en & (state != DONE). d_stall is 0 whenever data_sram_en=0.
- Read capture: on the data_data_ok cycle of a read, data_sram_rdata <= data_rdata. Writes and idle cycles leave it unchanged.
- data_wr = |data_sram_wen.
- data_wdata = data_sram_wdata, unmodified.
- Size derivation from data_sram_wen:
  - 0000 → size 10, address unchanged.
  - 1111 → size 10, addr[1:0] forced to 00.
  - 0011 → size 01, addr[1:0] = 00.
  - 1100 → size 01, addr[1:0] = 10.
  - One-hot bit i → size 00, addr[1:0] = i.
  - Any other pattern → size 10, addr[1:0] = 00, wen_illegal = 1 while data_sram_en is high. The transaction still proceeds.
- Request fields are combinational from the inputs. The pipeline holds its inputs stable while d_stall=1, so no request latch is required.
- Watchdog:
  - Counts cycles in which (IDLE & data_req & ~data_addr_ok) or WAIT.
  - Clears on entry to DONE.
  - When the count equals TIMEOUT_CYCLES, timeout_err <= 1 and stays set until reset. The transaction is not aborted.
  - The counter saturates at the limit.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
  - TIMEOUT_CYCLES=0: counter absent, timeout_err tied to 0.

Test Plan:
- Read, addr_ok at cycle 0, data_ok at cycle 3 with rdata=0xDEADBEEF → data_req high only in cycle 0; d_stall high cycles 0–3, low from cycle 4; data_sram_rdata=0xDEADBEEF from cycle 4.
- Byte write, wen=0100, addr=0x1003, addr_ok and data_ok in the same cycle → data_wr=1, data_size=00, data_addr=0x1002; DONE next cycle; data_sram_rdata unchanged.
- HOLD_UNTIL_RELEASE=1, longest_stall held for 3 cycles after data_ok → state stays DONE, data_req=0, d_stall=0 for those cycles; the next request issues only after longest_stall falls.
- Illegal wen=0110 → wen_illegal=1, data_size=10, data_addr[1:0]=00, write completes normally.
- TIMEOUT_CYCLES=4, addr_ok delayed 6 cycles → timeout_err rises after 4 outstanding cycles and stays 1 after completion; resetn=0 clears it.
- Reset asserted while in WAIT, then a stray data_ok → state IDLE, data_sram_rdata=0, stray data_ok ignored, next read completes normally.
